// File: rtl/mc_main_control.sv
// -----------------------------------------------------------------------------
// mc_main_control
// Multicycle main control FSM for the lab MIPS datapath. Decodes the opcode,
// sequences each instruction through fetch/decode/execute/memory/writeback,
// and drives ALU_op (to ALU_Control) plus every datapath mux select and write
// enable. Memory accesses handshake on mem_ready, so a slow memory simply
// holds the FSM in FETCH, MEMRD or MEMWR.
//
// Optional feature macro: MC_ADDI_EN
//   defined     -> opcode 001000 (addi) legal, via ADDI_EX -> ADDI_WB
//   not defined -> 001000 is treated like any other unrecognised opcode
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset (forces IDLE)
//   Opcode[5:0]  in   instruction[31:26]; looked at only in DECODE/MEMADR
//   mem_ready    in   memory access completes this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   RegWrite, RegDst, ALUSrcA          out  single-bit datapath controls
//   ALUSrcB[1:0] out   00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   PCSource[1:0] out  00 ALU result, 01 ALUOut, 10 jump target
//   ALU_op[1:0]  out   00 add, 01 subtract, 10 funct-decoded
//   retire       out   pulse in the last cycle of each instruction
//   illegal_op   out   pulse in DECODE on an unrecognised opcode
//
// Outputs are a combinational decode of the registered state (plus
// mem_ready in FETCH/MEMWR), so an asynchronous reset zeroes them at once.
// -----------------------------------------------------------------------------
module mc_main_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALU_op,
  output logic       retire,
  output logic       illegal_op
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXEC_R  = 4'd3;
  localparam logic [3:0] S_RWB_R   = 4'd4;
  localparam logic [3:0] S_MEMADR  = 4'd5;
  localparam logic [3:0] S_MEMRD   = 4'd6;
  localparam logic [3:0] S_MEMWB   = 4'd7;
  localparam logic [3:0] S_MEMWR   = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;
`ifdef MC_ADDI_EN
  localparam logic [3:0] S_ADDI_EX = 4'd11;
  localparam logic [3:0] S_ADDI_WB = 4'd12;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  logic       op_legal_s;

  // State register: reset parks the FSM in IDLE, abandoning any instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Opcode legality, used by DECODE for both next state and illegal_op.
  always_comb begin
    op_legal_s = 1'b0;
    case (Opcode)
      OP_RTYPE: op_legal_s = 1'b1;
      OP_LW:    op_legal_s = 1'b1;
      OP_SW:    op_legal_s = 1'b1;
      OP_BEQ:   op_legal_s = 1'b1;
      OP_J:     op_legal_s = 1'b1;
`ifdef MC_ADDI_EN
      OP_ADDI:  op_legal_s = 1'b1;
`endif
      default:  op_legal_s = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_IDLE:   next_state_s = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE: next_state_s = S_EXEC_R;
          OP_LW:    next_state_s = S_MEMADR;
          OP_SW:    next_state_s = S_MEMADR;
          OP_BEQ:   next_state_s = S_BRANCH;
          OP_J:     next_state_s = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:  next_state_s = S_ADDI_EX;
`endif
          default:  next_state_s = S_FETCH;
        endcase
      end
      S_EXEC_R: next_state_s = S_RWB_R;
      S_RWB_R:  next_state_s = S_FETCH;
      S_MEMADR: begin
        // Only lw and sw reach MEMADR; anything not sw is the load path.
        if (Opcode == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMWB:  next_state_s = S_FETCH;
      S_MEMWR: begin
        if (mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_BRANCH: next_state_s = S_FETCH;
      S_JUMP:   next_state_s = S_FETCH;
`ifdef MC_ADDI_EN
      S_ADDI_EX: next_state_s = S_ADDI_WB;
      S_ADDI_WB: next_state_s = S_FETCH;
`endif
      default:  next_state_s = S_FETCH;
    endcase
  end

  // Output decode: everything defaults to 0, each state raises its controls.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALU_op      = 2'b00;
    retire      = 1'b0;
    illegal_op  = 1'b0;
    case (state_r)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC+4 and IR only commit when the fetch actually completes.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = ~op_legal_s;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALU_op  = 2'b10;
      end
      S_RWB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_op      = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
`endif
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: the stimulus process pushes the
// hand-computed control word for every cycle it drives; the monitor pops and
// compares on the falling edge.
module tb_mc_main_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource, ALU_op;
  logic       retire, illegal_op;

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALU_op(ALU_op), .retire(retire), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word layout:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,
  //  RegDst,ALUSrcA,ALUSrcB[1:0],PCSource[1:0],ALU_op[1:0],retire,illegal_op}
  localparam logic [17:0] X_ZERO      = 18'd0;
  localparam logic [17:0] X_FETCH     = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] X_FETCH_ST  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] X_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] X_DEC_ILL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b1};
  localparam logic [17:0] X_EXEC_R    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,1'b0,1'b0};
  localparam logic [17:0] X_RWB_R     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] X_MEMADR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] X_MEMRD     = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] X_MEMWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] X_MEMWR_ST  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] X_MEMWR     = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] X_BRANCH    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0};
  localparam logic [17:0] X_JUMP      = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b1,1'b0};
`ifdef MC_ADDI_EN
  localparam logic [17:0] X_ADDI_EX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] X_ADDI_WB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef struct {
    logic [17:0] word;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  logic [17:0] act_s;

  assign act_s = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                  IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource,
                  ALU_op, retire, illegal_op};

  // One bench cycle: drive inputs just after the rising edge and queue the
  // control word expected for this cycle.
  task automatic cyc(input logic rs, input logic mr, input logic [5:0] op,
                     input logic [17:0] w, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rs;
    mem_ready = mr;
    Opcode    = op;
    e.word = w;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT control word mid-cycle against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp = n_cmp + 1;
      if (act_s !== e.word) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got %b expected %b", e.name, act_s, e.word);
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    Opcode    = 6'd0;

    // Reset held, then released: one IDLE cycle.
    cyc(1'b0, 1'b1, OP_R, X_ZERO, "reset0");
    cyc(1'b0, 1'b1, OP_R, X_ZERO, "reset1");
    cyc(1'b1, 1'b1, OP_R, X_ZERO, "idle");

    // R-type, mem_ready high: 4 cycles.
    cyc(1'b1, 1'b1, OP_R, X_FETCH,  "r_fetch");
    cyc(1'b1, 1'b1, OP_R, X_DECODE, "r_decode");
    cyc(1'b1, 1'b1, OP_R, X_EXEC_R, "r_exec");
    cyc(1'b1, 1'b1, OP_R, X_RWB_R,  "r_wb");

    // lw with two stall cycles in MEMRD.
    cyc(1'b1, 1'b1, OP_LW, X_FETCH,  "lw_fetch");
    cyc(1'b1, 1'b1, OP_LW, X_DECODE, "lw_decode");
    cyc(1'b1, 1'b1, OP_LW, X_MEMADR, "lw_memadr");
    cyc(1'b1, 1'b0, OP_LW, X_MEMRD,  "lw_memrd_st0");
    cyc(1'b1, 1'b0, OP_LW, X_MEMRD,  "lw_memrd_st1");
    cyc(1'b1, 1'b1, OP_LW, X_MEMRD,  "lw_memrd_go");
    cyc(1'b1, 1'b1, OP_LW, X_MEMWB,  "lw_memwb");

    // sw, no stall.
    cyc(1'b1, 1'b1, OP_SW, X_FETCH,  "sw_fetch");
    cyc(1'b1, 1'b1, OP_SW, X_DECODE, "sw_decode");
    cyc(1'b1, 1'b1, OP_SW, X_MEMADR, "sw_memadr");
    cyc(1'b1, 1'b1, OP_SW, X_MEMWR,  "sw_memwr");

    // beq and j: 3 cycles each.
    cyc(1'b1, 1'b1, OP_BEQ, X_FETCH,  "beq_fetch");
    cyc(1'b1, 1'b1, OP_BEQ, X_DECODE, "beq_decode");
    cyc(1'b1, 1'b1, OP_BEQ, X_BRANCH, "beq_branch");
    cyc(1'b1, 1'b1, OP_J,   X_FETCH,  "j_fetch");
    cyc(1'b1, 1'b1, OP_J,   X_DECODE, "j_decode");
    cyc(1'b1, 1'b1, OP_J,   X_JUMP,   "j_jump");

    // FETCH stalled 3 cycles, then an R-type completes.
    cyc(1'b1, 1'b0, OP_R, X_FETCH_ST, "fetch_st0");
    cyc(1'b1, 1'b0, OP_R, X_FETCH_ST, "fetch_st1");
    cyc(1'b1, 1'b0, OP_R, X_FETCH_ST, "fetch_st2");
    cyc(1'b1, 1'b1, OP_R, X_FETCH,    "fetch_go");
    cyc(1'b1, 1'b1, OP_R, X_DECODE,   "st_r_decode");
    cyc(1'b1, 1'b1, OP_R, X_EXEC_R,   "st_r_exec");
    cyc(1'b1, 1'b1, OP_R, X_RWB_R,    "st_r_wb");

    // Illegal opcode: pulse in DECODE, straight back to FETCH.
    cyc(1'b1, 1'b1, OP_BAD, X_FETCH,   "bad_fetch");
    cyc(1'b1, 1'b1, OP_BAD, X_DEC_ILL, "bad_decode");

    // addi: legal only with the feature enabled.
    cyc(1'b1, 1'b1, OP_ADDI, X_FETCH, "addi_fetch");
`ifdef MC_ADDI_EN
    cyc(1'b1, 1'b1, OP_ADDI, X_DECODE,  "addi_decode");
    cyc(1'b1, 1'b1, OP_ADDI, X_ADDI_EX, "addi_ex");
    cyc(1'b1, 1'b1, OP_ADDI, X_ADDI_WB, "addi_wb");
`else
    cyc(1'b1, 1'b1, OP_ADDI, X_DEC_ILL, "addi_illegal");
`endif

    // sw stalled in MEMWR, then reset mid-cycle while MemWrite is high.
    cyc(1'b1, 1'b1, OP_SW, X_FETCH,    "swr_fetch");
    cyc(1'b1, 1'b1, OP_SW, X_DECODE,   "swr_decode");
    cyc(1'b1, 1'b1, OP_SW, X_MEMADR,   "swr_memadr");
    cyc(1'b1, 1'b0, OP_SW, X_MEMWR_ST, "swr_memwr_st");
    cyc(1'b0, 1'b0, OP_SW, X_ZERO,     "swr_async_rst");
    cyc(1'b0, 1'b1, OP_SW, X_ZERO,     "swr_rst_hold");
    cyc(1'b1, 1'b1, OP_SW, X_ZERO,     "swr_idle");
    cyc(1'b1, 1'b1, OP_R,  X_FETCH,    "swr_refetch");

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() > 0) begin
        @(posedge clk);
      end
    end
    if (exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multicycle main control FSM for the lab MIPS datapath. Sits directly upstream of `ALU_Control`: it decodes the instruction opcode, sequences each instruction through fetch/decode/execute/memory/writeback, and drives `ALU_op` together with all datapath mux selects and write enables. Memory accesses use a ready handshake, so variable-latency memory stalls the FSM.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `Opcode`  in  6  instruction[31:26], valid from DECODE onward (IR latched)
- `mem_ready`  in  1  memory access completes this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each  standard multicycle controls
- `ALUSrcB`  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `ALU_op`  out  2  to `ALU_Control`: 00 add, 01 subtract, 10 funct-decoded
- `retire`  out  1  one-cycle pulse in the last cycle of each instruction
- `illegal_op`  out  1  one-cycle pulse in DECODE on an unrecognised opcode

## Operation
- Decision made: one clock, `rst_n` asynchronous active-low.
- Registered 4-bit state; every output is a combinational decode of state (plus `mem_ready` where noted). Unlisted outputs are 0.
- IDLE: all outputs 0. Entered on reset; leaves to FETCH on the first clock edge after `rst_n` rises.
- FETCH: MemRead=1, ALUSrcA=0, IorD=0, ALUSrcB=01, ALU_op=00, PCSource=00; IRWrite=PCWrite=`mem_ready`. Stays while `mem_ready`=0, goes to DECODE when 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=00. Next state by Opcode: 000000 EXEC_R; 100011 or 101011 MEMADR; 000100 BRANCH; 000010 JUMP; otherwise `illegal_op`=1 and go to FETCH (no `retire`).
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALU_op=10 -> RWB_R.
- RWB_R: RegDst=1, RegWrite=1, MemtoReg=0, `retire`=1 -> FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_op=00 -> MEMRD (lw) or MEMWR (sw).
- MEMRD: MemRead=1, IorD=1; waits on `mem_ready`, then -> MEMWB.
- MEMWB: RegDst=0, RegWrite=1, MemtoReg=1, `retire`=1 -> FETCH.
- MEMWR: MemWrite=1, IorD=1; waits on `mem_ready`; `retire`=`mem_ready`; then -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_op=01, PCWriteCond=1, PCSource=01, `retire`=1 -> FETCH.
- JUMP: PCWrite=1, PCSource=10, `retire`=1 -> FETCH.
- Any unused state encoding: outputs 0, next state FETCH.

## Timing
- Instruction latency with `mem_ready` tied high: R-type 4, lw 5, sw 4, beq 3, j 3 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. No write enable is asserted during a stall cycle, except MemRead and MemWrite, which are held.
- `rst_n` low at any time: state becomes IDLE immediately (asynchronously) and all outputs go to 0 in the same cycle. Any instruction in flight is abandoned.
- Opcode is sampled only in DECODE and MEMADR. It is don't-care elsewhere.

## Configuration
- `MC_ADDI_EN` defined: opcode 001000 (addi) is legal. Path: DECODE -> ADDI_EX (ALUSrcA=1, ALUSrcB=10, ALU_op=00) -> ADDI_WB (RegDst=0, RegWrite=1, MemtoReg=0, `retire`=1) -> FETCH. Latency 4 cycles.
- Not defined: 001000 is illegal, as any other unrecognised opcode is. Both ADDI states are absent.

## Test plan
- Reset, then `mem_ready`=1 with Opcode=000000 -> IDLE, FETCH, DECODE, EXEC_R (ALU_op=10), RWB_R (RegWrite=1, RegDst=1, `retire`=1), then FETCH.
- lw (100011) with `mem_ready` low for 2 cycles in MEMRD -> MemRead/IorD held for 3 cycles, then MEMWB with MemtoReg=1 and `retire` exactly once.
- beq (000100) -> BRANCH cycle shows ALU_op=01, PCWriteCond=1, PCSource=01. j (000010) -> PCWrite=1, PCSource=10.
- FETCH with `mem_ready`=0 for 3 cycles -> IRWrite=PCWrite=0 throughout, then both 1 for exactly one cycle.
- Opcode=111111 -> `illegal_op` pulses once in DECODE, no `retire`, next state FETCH. Opcode=001000 behaves as illegal without `MC_ADDI_EN` and gives a 4-cycle addi with it.
- `rst_n` asserted low during MEMWR while MemWrite=1 -> all outputs 0 before the next edge. After release, IDLE for one cycle, then FETCH.
